// File: rtl/decode_issue_pkg.sv
// Shared decode constants for the RV32I decode/issue stage and the ALU it feeds.
package decode_issue_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_COUNT = 32;
  localparam int unsigned REG_AW    = 5;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  localparam logic [2:0] ADD_SUB = 3'b000;
  localparam logic [2:0] SLL     = 3'b001;
  localparam logic [2:0] SLT     = 3'b010;
  localparam logic [2:0] SLTU    = 3'b011;
  localparam logic [2:0] XOR     = 3'b100;
  localparam logic [2:0] SRL_SRA = 3'b101;
  localparam logic [2:0] OR      = 3'b110;
  localparam logic [2:0] AND     = 3'b111;

  localparam logic [6:0] F7_SUB_SRA = 7'b0100000;

endpackage

// File: rtl/decode_issue_regfile_2r1w.sv
// Register file: two combinational read ports, one synchronous write port, x0 reads zero.
module regfile_2r1w
  import decode_issue_pkg::*;
(
  input  logic              clk,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [XLEN-1:0]   rdata1,
  output logic [XLEN-1:0]   rdata2,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [XLEN-1:0]   wdata
);

  logic [XLEN-1:0] mem [REG_COUNT];

  always_ff @(posedge clk) begin
    if (we && (waddr != '0)) mem[waddr] <= wdata;
  end

  assign rdata1 = (raddr1 == '0) ? '0 : mem[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : mem[raddr2];

endmodule

// File: rtl/decode_issue.sv
// RV32I decode/issue stage with busy-bit hazard stalls and one registered ALU op slot.
// Optional macro DECODE_WB_BYPASS_EN forwards same-cycle writeback data to the sources.
module decode_issue
  import decode_issue_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [XLEN-1:0]   in_pc,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [6:0]        out_opcode,
  output logic [2:0]        out_funct3,
  output logic [6:0]        out_funct7,
  output logic [XLEN-1:0]   out_in1,
  output logic [XLEN-1:0]   out_in2,
  output logic [REG_AW-1:0] out_rd,
  output logic [XLEN-1:0]   out_pc,
  output logic              out_illegal
);

  logic [6:0]        opcode;
  logic [REG_AW-1:0] rd;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [XLEN-1:0]   imm_i;
  logic [XLEN-1:0]   imm_u;

  assign opcode = in_instr[6:0];
  assign rd     = in_instr[11:7];
  assign funct3 = in_instr[14:12];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];
  assign funct7 = in_instr[31:25];
  assign imm_i  = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign imm_u  = {in_instr[31:12], 12'b0};

  logic [XLEN-1:0] rdata1;
  logic [XLEN-1:0] rdata2;

  regfile_2r1w u_regfile (
    .clk    (clk),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rdata1),
    .rdata2 (rdata2),
    .we     (wb_en),
    .waddr  (wb_rd),
    .wdata  (wb_data)
  );

  logic byp1;
  logic byp2;

`ifdef DECODE_WB_BYPASS_EN
  assign byp1 = wb_en && (wb_rd == rs1) && (rs1 != '0);
  assign byp2 = wb_en && (wb_rd == rs2) && (rs2 != '0);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;

  assign src1 = byp1 ? wb_data : rdata1;
  assign src2 = byp2 ? wb_data : rdata2;

  logic is_op;
  logic is_opimm;
  logic is_lui;
  logic is_auipc;
  logic legal;

  assign is_op    = (opcode == OP);
  assign is_opimm = (opcode == OP_IMM);
  assign is_lui   = (opcode == LUI);
  assign is_auipc = (opcode == AUIPC);
  assign legal    = is_op | is_opimm | is_lui | is_auipc;

  logic [REG_COUNT-1:0] busy;
  logic [REG_COUNT-1:0] busy_next;
  logic                 hazard;
  logic                 accept;

  // busy[0] is never set, so x0 can never create a hazard
  assign hazard = ((is_op | is_opimm) & busy[rs1] & ~byp1)
                | (is_op & busy[rs2] & ~byp2)
                | (legal & busy[rd]);

  assign in_ready = (~out_valid | out_ready) & ~hazard;
  assign accept   = in_valid & in_ready;

  logic [2:0]        d_funct3;
  logic [6:0]        d_funct7;
  logic [XLEN-1:0]   d_in1;
  logic [XLEN-1:0]   d_in2;
  logic [REG_AW-1:0] d_rd;

  always_comb begin
    d_funct3 = '0;
    d_funct7 = '0;
    d_in1    = '0;
    d_in2    = '0;
    d_rd     = '0;
    if (is_op) begin
      d_funct3 = funct3;
      d_funct7 = funct7;
      d_in1    = src1;
      d_in2    = src2;
      d_rd     = rd;
    end else if (is_opimm) begin
      d_funct3 = funct3;
      d_in1    = src1;
      d_rd     = rd;
      // only shifts carry funct7; otherwise ADDI could look like SUB
      if ((funct3 == SLL) || (funct3 == SRL_SRA)) begin
        d_funct7 = funct7;
        d_in2    = XLEN'(in_instr[24:20]);
      end else begin
        d_in2    = imm_i;
      end
    end else if (is_lui) begin
      d_in2 = imm_u;
      d_rd  = rd;
    end else if (is_auipc) begin
      d_in1 = in_pc;
      d_in2 = imm_u;
      d_rd  = rd;
    end
  end

  // set beats clear when the same register is both issued and written back
  always_comb begin
    busy_next = busy;
    if (wb_en && (wb_rd != '0)) busy_next[wb_rd] = 1'b0;
    if (accept && legal && (rd != '0)) busy_next[rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy        <= '0;
      out_valid   <= 1'b0;
      out_opcode  <= '0;
      out_funct3  <= '0;
      out_funct7  <= '0;
      out_in1     <= '0;
      out_in2     <= '0;
      out_rd      <= '0;
      out_pc      <= '0;
      out_illegal <= 1'b0;
    end else begin
      busy <= busy_next;
      if (accept) begin
        out_valid   <= 1'b1;
        out_opcode  <= opcode;
        out_funct3  <= d_funct3;
        out_funct7  <= d_funct7;
        out_in1     <= d_in1;
        out_in2     <= d_in2;
        out_rd      <= d_rd;
        out_pc      <= in_pc;
        out_illegal <= ~legal;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/decode_issue.md
Name: decode_issue

Overview:
- Decode/issue stage that produces the operands and function codes consumed by the combinational ALU.
- Accepts one RV32I instruction word plus PC per handshake from fetch. Decodes opcode/funct3/funct7/rd and the immediate. Reads a local 32x32 register file.
- Stalls on register hazards using a busy-bit scoreboard. Presents one registered ALU operation per handshake downstream.
- The writeback port writes the register file and clears scoreboard bits.

Parameters:
- XLEN, 32, datapath width of operands, register file and PC.
- REG_COUNT, 32, architectural registers; x0 is hardwired to zero.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  fetch offers instruction
- in_ready  out  1  stage accepts instruction this cycle
- in_instr  in  32  instruction word
- in_pc  in  XLEN  PC of in_instr
- wb_en  in  1  writeback strobe
- wb_rd  in  5  writeback destination
- wb_data  in  XLEN  writeback value
- out_valid  out  1  ALU operation held
- out_ready  in  1  downstream consumes operation
- out_opcode  out  7  opcode to ALU
- out_funct3  out  3  funct3 to ALU
- out_funct7  out  7  funct7 to ALU
- out_in1  out  XLEN  operand 1
- out_in2  out  XLEN  operand 2
- out_rd  out  5  destination register
- out_pc  out  XLEN  PC of issued instruction
- out_illegal  out  1  opcode not supported

Behaviour:
- Reset (clk edge with rst_n=0): all out_* = 0, out_valid=0, all scoreboard busy bits = 0. Register file contents are not reset; reads of x0 always return 0.
- Reset mid-operation discards the held operation; no completion is reported.
- Fields:
  - opcode=instr[6:0], rd=[11:7], funct3=[14:12], rs1=[19:15], rs2=[24:20].
  - imm_i = sign-extended [31:20].
  - imm_u = {[31:12], 12'b0}.
- OP (0110011): in1=R[rs1], in2=R[rs2], funct7=instr[31:25].
- OP-IMM (0010011): in1=R[rs1], in2=imm_i. funct7=instr[31:25] only when funct3 is 001 or 101 (shifts); otherwise funct7=0, so ADDI never selects subtract. in2 for shifts is zero-extended shamt [24:20].
- LUI (0110111): in1=0, in2=imm_u, funct3=000, funct7=0.
- AUIPC (0010111): in1=in_pc, in2=imm_u, funct3=000, funct7=0.
- Any other opcode: out_illegal=1, in1=in2=0, rd forced to 0, no scoreboard set.
- Hazard: stall if any of the following is busy (x0 is never busy):
  - rs1, when the instruction is OP or OP-IMM;
  - rs2, when the instruction is OP;
  - rd, for any legal instruction with rd≠0 (WAW).
- in_ready = (!out_valid | out_ready) & !hazard. in_ready may depend combinationally on in_instr; fetch must hold in_instr/in_pc stable while in_valid && !in_ready.
- Accept (in_valid & in_ready): output register loads next edge, out_valid=1; set busy[rd] if legal and rd≠0. Latency 1 cycle from accept to out_valid.
- out_valid && !out_ready: all out_* held stable.
- out_ready && !accept: out_valid clears next edge.
- Writeback: wb_en && wb_rd≠0 writes R[wb_rd] and clears busy[wb_rd] at the edge. wb_rd=0 is ignored.
- Simultaneous set and clear of the same busy bit: set wins.
- wb_en to a non-busy register: data written, scoreboard unchanged.
- Same-cycle read and write of the same register without bypass: the read returns the old value. This is harmless because a busy source already stalls.

Optional Feature:
- DECODE_WB_BYPASS_EN defined:
  - In the writeback cycle, a source equal to wb_rd (≠0) takes wb_data.
  - That source is treated as not busy, so the dependent instruction issues the same cycle.
- DECODE_WB_BYPASS_EN undefined:
  - The dependent instruction issues one cycle after the writeback edge.

Decomposition:
- Shared package/include holds:
  - opcode constants OP, OP_IMM, LUI, AUIPC;
  - funct3 codes ADD_SUB, SLL, SLT, SLTU, XOR, SRL_SRA, OR, AND (the same names the ALU uses);
  - funct7 SUB/SRA value 7'b0100000.
- One natural sub-module: regfile_2r1w (two combinational read ports, one synchronous write port, x0 reads zero).
- Scoreboard and immediate generation stay inline.

Test Plan:
- ADDI x1,x0,-5 (0xFFB00093), pc=0x100 → next cycle out_in1=0, out_in2=0xFFFFFFFB, funct3=000, funct7=0, rd=1, out_valid=1; busy[1]=1.
- ADD x2,x1,x1 issued right after ADDI x1 → in_ready=0 until wb_en, wb_rd=1, wb_data=0xFFFFFFFB. Issue lands the same cycle with bypass, one cycle later without it; out_in1=out_in2=0xFFFFFFFB.
- SRAI x3,x4,7 (funct7=0100000) with R[4]=0x80000000 → out_funct7=0x20, funct3=101, out_in2=7.
- AUIPC x5,0x12345 at pc=0x200 → out_in1=0x200, out_in2=0x12345000. LUI → out_in1=0.
- out_ready=0 for 3 cycles with a second instruction waiting → outputs stable, in_ready=0; accept occurs on the cycle out_ready=1.
- Opcode 0x7F → out_illegal=1, rd=0, no busy bit set. Then assert rst_n=0 mid-stall → out_valid=0 and busy cleared the next cycle.
